ttc_trigger_dispatcher: RTL and testbench
=========================================

TTC_TRIGGER_DISPATCHER -- requirements
Module: ttc_trigger_dispatcher

Interface
REQ-001 Parameter NUM_CHAN, default 5: number of acquisition channels, legal range 1..8.
REQ-002 Parameter ACCEPT_TYPE, default 5'b00100: trigger type that launches a channel readout.
REQ-003 Parameter READY_TIMEOUT, default 1024: cycles to wait for channel readiness before the block declares an error.
REQ-004 Port clk, input, 1 bit: 40 MHz TTC clock.
REQ-005 Port reset, input, 1 bit: synchronous, active-high; clock clk.
REQ-006 Ports reset_trig_num and reset_trig_timestamp, inputs, 1 bit each: TTC Channel B counter resets.
REQ-007 Ports ttc_trigger (1 bit) and trig_type (5 bits), inputs: trigger strobe and its type.
REQ-008 Ports chan_en, acq_ready, acq_activated and selftriggers_seen, inputs, NUM_CHAN bits each: per-channel enable, ready, acquiring and self-trigger-seen flags.
REQ-009 Ports xadc_alarms (4 bits) and error_clear (1 bit), inputs: XADC alarm levels and the recovery request for the ERROR state.
REQ-010 Ports acq_trigger (1 bit), acq_trig_type (5 bits) and acq_trig_num (24 bits), outputs: readout launch pulse, latched trigger type and latched trigger number.
REQ-011 Ports fifo_ready (input, 1 bit), fifo_valid (output, 1 bit) and fifo_data (output, 128 bits): trigger-info FIFO handshake and payload.
REQ-012 Ports state (3 bits), trig_num (24 bits) and trig_timestamp (44 bits), outputs: FSM state, global trigger number and latched timestamp.
REQ-013 Ports error_trig_rate, error_ready_timeout (1 bit each) and dropped_trig_cnt (16 bits), outputs: error flags and dropped-trigger count.

Function
REQ-014 FSM states: IDLE=0, WAIT_READY=1, STORE=2, ERROR=3, binary-encoded on the state output.
REQ-015 A free-running 44-bit timestamp counter increments every cycle and wraps modulo 2^44.
REQ-016 In IDLE with ttc_trigger=1, the block latches the following and moves to WAIT_READY:
  - acq_trig_num <= trig_num; trig_num <= trig_num+1;
  - acq_trig_type <= trig_type;
  - trig_timestamp <= timestamp counter value in that cycle;
  - xadc_alarms captured.
REQ-017 empty_event = (trig_type != ACCEPT_TYPE) or chan_en==0 or (acq_activated & chan_en)==0; evaluated at latch time.
REQ-018 empty_payload = not empty_event and (selftriggers_seen & chan_en)==0; evaluated at latch time.
REQ-019 The ready condition is &(acq_ready | ~chan_en).
REQ-020 In WAIT_READY with the ready condition true, the block moves to STORE; for a non-empty event it also pulses acq_trigger for exactly 1 cycle and increments acq_event_cnt (24 bits).
REQ-021 In WAIT_READY with the ready condition false for READY_TIMEOUT consecutive cycles, the block sets error_ready_timeout and moves to ERROR.
REQ-022 Latency: trigger sampled in cycle T gives the acq_trigger pulse and first fifo_valid in cycle T+2 when the channels are ready.
REQ-023 In STORE, fifo_valid=1 and fifo_data is held stable until fifo_valid&fifo_ready; the cycle after the transfer the block is in IDLE with fifo_valid=0.
REQ-024 fifo_data layout:
  - [43:0] timestamp; [67:44] acq_trig_num; [91:68] acq_event_cnt;
  - [96:92] acq_trig_type; [97] empty_event; [101:98] xadc_alarms; [102] empty_payload;
  - [110:103] chan_en zero-extended to 8 bits; [127:111] zero.
REQ-025 A ttc_trigger sampled outside IDLE is dropped:
  - trig_num still increments;
  - dropped_trig_cnt increments, saturating at 0xFFFF;
  - error_trig_rate is set and stays set.
REQ-026 ERROR holds with fifo_valid=0 and acq_trigger=0 until error_clear=1, then returns to IDLE; error_clear clears both error flags and dropped_trig_cnt.
REQ-027 reset_trig_num sets trig_num, acq_trig_num and acq_event_cnt to 1.
REQ-028 reset_trig_timestamp sets the timestamp counter and trig_timestamp to 0.
REQ-029 reset_trig_num and reset_trig_timestamp take priority over a same-cycle increment and do not change the FSM state.
REQ-030 trig_num and acq_event_cnt wrap 0xFFFFFF -> 0.

Reset
REQ-031 reset gives: state=IDLE, fifo_valid=0, fifo_data=0, acq_trigger=0, acq_trig_type=0, trig_num=acq_trig_num=acq_event_cnt=1, timestamps=0, error flags=0, dropped_trig_cnt=0, timeout counter=0.
REQ-032 reset asserted during STORE discards the pending word with no FIFO transfer.

Structure
REQ-033 The state encodings, FIFO field offsets and ACCEPT_TYPE default belong in a shared TTC trigger package.
REQ-034 The timeout down-counter is a sub-module, ready_timeout_counter, parametrised by READY_TIMEOUT.

Verification
REQ-035 Type 5'b00100, chan_en=5'h1F, all ready/activated/seen -> acq_trigger at T+2; FIFO word has empty_event=0, empty_payload=0, acq_trig_num=1, acq_event_cnt=1.
REQ-036 Type 5'b00001 -> no acq_trigger; FIFO word has empty_event=1; acq_event_cnt stays 1; trig_num becomes 2.
REQ-037 chan_en=5'h03, acq_ready=5'h1C held for 1024 cycles -> error_ready_timeout=1, state=ERROR; error_clear pulse -> IDLE, flags cleared.
REQ-038 fifo_ready=0 for 10 cycles while 3 triggers arrive -> fifo_data stable, dropped_trig_cnt=3, error_trig_rate=1, trig_num=5.
REQ-039 selftriggers_seen=0 with a valid async trigger -> empty_payload=1, acq_trigger still pulses once.
REQ-040 reset_trig_num in the same cycle as a trigger -> trig_num=1 and acq_trig_num=1 in the following cycle.

Source files
------------

// File: rtl/ttc_trigger_dispatcher_pkg.sv
// Shared TTC trigger definitions: FSM state encoding, trigger-info word layout
// and the default accepted trigger type.
package ttc_trigger_dispatcher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_STORE      = 3'd2,
    ST_ERROR      = 3'd3
  } state_t;

  localparam logic [4:0]  DEFAULT_ACCEPT_TYPE = 5'b00100;
  localparam int unsigned FIFO_W              = 128;

  localparam int unsigned OFS_TIMESTAMP     = 0;
  localparam int unsigned OFS_TRIG_NUM      = 44;
  localparam int unsigned OFS_EVENT_CNT     = 68;
  localparam int unsigned OFS_TRIG_TYPE     = 92;
  localparam int unsigned OFS_EMPTY_EVENT   = 97;
  localparam int unsigned OFS_XADC          = 98;
  localparam int unsigned OFS_EMPTY_PAYLOAD = 102;
  localparam int unsigned OFS_CHAN_EN       = 103;

  typedef struct packed {
    logic [7:0]  chan_en;
    logic        empty_payload;
    logic [3:0]  xadc_alarms;
    logic        empty_event;
    logic [4:0]  trig_type;
    logic [23:0] event_cnt;
    logic [23:0] trig_num;
    logic [43:0] timestamp;
  } trig_info_t;

  function automatic logic [FIFO_W-1:0] pack_trig_info(input trig_info_t t);
    logic [FIFO_W-1:0] w;
    w = '0;
    w[OFS_TIMESTAMP +: 44]   = t.timestamp;
    w[OFS_TRIG_NUM +: 24]    = t.trig_num;
    w[OFS_EVENT_CNT +: 24]   = t.event_cnt;
    w[OFS_TRIG_TYPE +: 5]    = t.trig_type;
    w[OFS_EMPTY_EVENT]       = t.empty_event;
    w[OFS_XADC +: 4]         = t.xadc_alarms;
    w[OFS_EMPTY_PAYLOAD]     = t.empty_payload;
    w[OFS_CHAN_EN +: 8]      = t.chan_en;
    return w;
  endfunction

endpackage

// File: rtl/ttc_trigger_dispatcher_if.sv
// Trigger-info FIFO valid/ready handshake between the dispatcher and the FIFO.
interface ttc_trigger_dispatcher_if;
  logic                                         fifo_valid;
  logic                                         fifo_ready;
  logic [ttc_trigger_dispatcher_pkg::FIFO_W-1:0] fifo_data;

  modport master (output fifo_valid, output fifo_data, input fifo_ready);
  modport slave  (input fifo_valid, input fifo_data, output fifo_ready);
endinterface

// File: rtl/ttc_trigger_dispatcher_ready_timeout_counter.sv
// Down-counter that flags when channel readiness has been missing for
// READY_TIMEOUT consecutive decrement cycles.
module ready_timeout_counter #(
  parameter int unsigned READY_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expired
);
  localparam int unsigned CW = $clog2(READY_TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)       r_cnt <= '0;
    else if (i_load) r_cnt <= CW'(READY_TIMEOUT);
    else if (i_dec)  r_cnt <= r_cnt - CW'(1);
    else             r_cnt <= '0;
  end

  // Fires on the last not-ready cycle so the FSM leaves on exactly that edge.
  assign o_expired = i_dec && (r_cnt == CW'(1));
endmodule

// File: rtl/ttc_trigger_dispatcher.sv
// TTC trigger dispatcher: numbers and timestamps triggers, launches channel
// readouts and pushes one trigger-info word per accepted trigger.
module ttc_trigger_dispatcher
  import ttc_trigger_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_CHAN      = 5,
  parameter logic [4:0]  ACCEPT_TYPE   = DEFAULT_ACCEPT_TYPE,
  parameter int unsigned READY_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_trig_num,
  input  logic                reset_trig_timestamp,
  input  logic                ttc_trigger,
  input  logic [4:0]          trig_type,
  input  logic [NUM_CHAN-1:0] chan_en,
  input  logic [NUM_CHAN-1:0] acq_ready,
  input  logic [NUM_CHAN-1:0] acq_activated,
  input  logic [NUM_CHAN-1:0] selftriggers_seen,
  input  logic [3:0]          xadc_alarms,
  input  logic                error_clear,
  output logic                acq_trigger,
  output logic [4:0]          acq_trig_type,
  output logic [23:0]         acq_trig_num,
  ttc_trigger_dispatcher_if.master fifo,
  output logic [2:0]          state,
  output logic [23:0]         trig_num,
  output logic [43:0]         trig_timestamp,
  output logic                error_trig_rate,
  output logic                error_ready_timeout,
  output logic [15:0]         dropped_trig_cnt
);
  state_t              r_state;
  logic                r_acq_trigger, r_fifo_valid;
  logic [4:0]          r_acq_trig_type;
  logic [23:0]         r_acq_trig_num, r_trig_num, r_event_cnt;
  logic [43:0]         r_ts, r_trig_ts;
  logic [3:0]          r_xadc;
  logic [7:0]          r_chan_en;
  logic                r_empty_event, r_empty_payload;
  logic [FIFO_W-1:0]   r_fifo_data;
  logic                r_err_rate, r_err_timeout;
  logic [15:0]         r_dropped;

  logic       w_ready, w_empty_event, w_empty_payload, w_accept, w_wait_dec, w_expired;
  logic [7:0] w_chan_en8;
  trig_info_t w_info;

  always_comb begin
    w_chan_en8                 = '0;
    w_chan_en8[NUM_CHAN-1:0]   = chan_en;
    w_ready         = &(acq_ready | ~chan_en);
    w_empty_event   = (trig_type != ACCEPT_TYPE) || (chan_en == '0) ||
                      ((acq_activated & chan_en) == '0);
    w_empty_payload = !w_empty_event && ((selftriggers_seen & chan_en) == '0);
    w_accept        = (r_state == ST_IDLE) && ttc_trigger;
    w_wait_dec      = (r_state == ST_WAIT_READY) && !w_ready;
    w_info          = '{chan_en: r_chan_en, empty_payload: r_empty_payload,
                        xadc_alarms: r_xadc, empty_event: r_empty_event,
                        trig_type: r_acq_trig_type, event_cnt: r_event_cnt,
                        trig_num: r_acq_trig_num, timestamp: r_trig_ts};
  end

  ready_timeout_counter #(.READY_TIMEOUT(READY_TIMEOUT)) u_ready_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_accept),
    .i_dec     (w_wait_dec),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_acq_trigger   <= 1'b0;
      r_fifo_valid    <= 1'b0;
      r_fifo_data     <= '0;
      r_acq_trig_type <= '0;
      r_acq_trig_num  <= 24'd1;
      r_trig_num      <= 24'd1;
      r_event_cnt     <= 24'd1;
      r_ts            <= '0;
      r_trig_ts       <= '0;
      r_xadc          <= '0;
      r_chan_en       <= '0;
      r_empty_event   <= 1'b0;
      r_empty_payload <= 1'b0;
      r_err_rate      <= 1'b0;
      r_err_timeout   <= 1'b0;
      r_dropped       <= '0;
    end else begin
      r_acq_trigger <= 1'b0;
      r_ts          <= r_ts + 44'd1;
      if (ttc_trigger) r_trig_num <= r_trig_num + 24'd1;

      if (error_clear) begin
        r_err_rate    <= 1'b0;
        r_err_timeout <= 1'b0;
        r_dropped     <= '0;
      end else if (ttc_trigger && (r_state != ST_IDLE)) begin
        r_err_rate <= 1'b1;
        if (r_dropped != '1) r_dropped <= r_dropped + 16'd1;
      end

      case (r_state)
        ST_IDLE: if (ttc_trigger) begin
          r_acq_trig_num  <= r_trig_num;
          r_acq_trig_type <= trig_type;
          r_trig_ts       <= r_ts;
          r_xadc          <= xadc_alarms;
          r_chan_en       <= w_chan_en8;
          r_empty_event   <= w_empty_event;
          r_empty_payload <= w_empty_payload;
          r_state         <= ST_WAIT_READY;
        end
        ST_WAIT_READY: if (w_ready) begin
          r_fifo_valid <= 1'b1;
          r_fifo_data  <= pack_trig_info(w_info);
          r_state      <= ST_STORE;
          if (!r_empty_event) begin
            r_acq_trigger <= 1'b1;
            r_event_cnt   <= r_event_cnt + 24'd1;
          end
        end else if (w_expired) begin
          r_err_timeout <= 1'b1;
          r_state       <= ST_ERROR;
        end
        ST_STORE: if (fifo.fifo_ready) begin
          r_fifo_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
        ST_ERROR: if (error_clear) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase

      // Channel B counter resets override any increment or latch above.
      if (reset_trig_num) begin
        r_trig_num     <= 24'd1;
        r_acq_trig_num <= 24'd1;
        r_event_cnt    <= 24'd1;
      end
      if (reset_trig_timestamp) begin
        r_ts      <= '0;
        r_trig_ts <= '0;
      end
    end
  end

  assign acq_trigger         = r_acq_trigger;
  assign acq_trig_type       = r_acq_trig_type;
  assign acq_trig_num        = r_acq_trig_num;
  assign fifo.fifo_valid     = r_fifo_valid;
  assign fifo.fifo_data      = r_fifo_data;
  assign state               = r_state;
  assign trig_num            = r_trig_num;
  assign trig_timestamp      = r_trig_ts;
  assign error_trig_rate     = r_err_rate;
  assign error_ready_timeout = r_err_timeout;
  assign dropped_trig_cnt    = r_dropped;
endmodule

// File: tb/tb_ttc_trigger_dispatcher.sv
// Self-checking bench for ttc_trigger_dispatcher: directed vector table,
// multi-cycle corner sequences and a randomized run against a transaction model.
module tb_ttc_trigger_dispatcher;
  localparam logic [4:0] ACC = 5'b00100;

  logic        clk = 1'b0;
  logic        reset, rtn, rtt, ttc_trigger, error_clear;
  logic [4:0]  trig_type;
  logic [4:0]  chan_en, acq_ready, acq_activated, seen;
  logic [3:0]  xadc;
  logic        acq_trigger, err_rate, err_to;
  logic [4:0]  acq_trig_type;
  logic [23:0] acq_trig_num, trig_num;
  logic [2:0]  state;
  logic [43:0] trig_timestamp;
  logic [15:0] dropped;

  ttc_trigger_dispatcher_if fif ();

  ttc_trigger_dispatcher #(.NUM_CHAN(5), .ACCEPT_TYPE(5'b00100), .READY_TIMEOUT(1024)) dut (
    .clk(clk), .reset(reset), .reset_trig_num(rtn), .reset_trig_timestamp(rtt),
    .ttc_trigger(ttc_trigger), .trig_type(trig_type), .chan_en(chan_en),
    .acq_ready(acq_ready), .acq_activated(acq_activated), .selftriggers_seen(seen),
    .xadc_alarms(xadc), .error_clear(error_clear), .acq_trigger(acq_trigger),
    .acq_trig_type(acq_trig_type), .acq_trig_num(acq_trig_num), .fifo(fif),
    .state(state), .trig_num(trig_num), .trig_timestamp(trig_timestamp),
    .error_trig_rate(err_rate), .error_ready_timeout(err_to), .dropped_trig_cnt(dropped)
  );

  always #12 clk = ~clk;

  // Reference free-running timestamp: value visible during the current cycle.
  logic [43:0] m_ts;
  always @(posedge clk) m_ts <= (reset || rtt) ? 44'd0 : m_ts + 44'd1;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rtn = 0; rtt = 0; ttc_trigger = 0; error_clear = 0; trig_type = '0;
    chan_en = '1; acq_ready = '1; acq_activated = '1; seen = '1; xadc = '0;
    fif.fifo_ready = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 1; step(); step(); reset = 0;
  endtask

  function automatic logic [127:0] word(logic [43:0] ts, logic [23:0] tn, logic [23:0] ev,
      logic [4:0] ty, logic ee, logic [3:0] xa, logic ep, logic [4:0] ce);
    return {17'd0, 3'd0, ce, ep, xa, ee, ty, ev, tn, ts};
  endfunction

  typedef struct {
    logic       rst;
    logic [4:0] ty, ce, act, sn, rdy;
    logic [3:0] xa;
    logic       e_ee, e_ep;
  } vec_t;

  vec_t        vt[8];
  logic [23:0] exp_tn, exp_ev;
  logic [43:0] ts_exp;
  logic [127:0] w_exp;

  // Random-run model state
  logic [23:0] mtn, mat, mev;
  logic [43:0] mtts, cur_ts;
  logic [15:0] mdrop;
  logic        mrate, busy, shown, pb, ps, rdy, exp_pulse;
  logic [4:0]  ev_ty, ev_ce, m_type;
  logic [3:0]  ev_xa;
  logic        ev_ee, ev_ep;
  logic [127:0] exp_w;

  initial begin
    idle_inputs();
    reset = 1;
    step(); step();

    // Reset state, sampled while reset is still held
    chk("rst_state", state, 0);            chk("rst_valid", fif.fifo_valid, 0);
    chk("rst_data", fif.fifo_data, 0);     chk("rst_acq_trigger", acq_trigger, 0);
    chk("rst_acq_type", acq_trig_type, 0); chk("rst_trig_num", trig_num, 1);
    chk("rst_acq_num", acq_trig_num, 1);   chk("rst_tts", trig_timestamp, 0);
    chk("rst_err_rate", err_rate, 0);      chk("rst_err_to", err_to, 0);
    chk("rst_dropped", dropped, 0);
    reset = 0;

    //        rst  type      chan_en activ  seen   ready  xadc  ee  ep
    vt[0] = '{1, 5'b00001, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 4'h5, 1, 0};
    vt[1] = '{0, 5'b00100, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 4'h0, 0, 0};
    vt[2] = '{1, 5'b00100, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 4'hA, 0, 0};
    vt[3] = '{0, 5'b00100, 5'h1F, 5'h1F, 5'h00, 5'h1F, 4'h3, 0, 1};
    vt[4] = '{0, 5'b00100, 5'h00, 5'h1F, 5'h1F, 5'h00, 4'h0, 1, 0};
    vt[5] = '{0, 5'b00100, 5'h03, 5'h1C, 5'h1F, 5'h1F, 4'hF, 1, 0};
    vt[6] = '{0, 5'b00100, 5'h03, 5'h01, 5'h1C, 5'h1F, 4'h1, 0, 1};
    vt[7] = '{0, 5'b00100, 5'h1C, 5'h04, 5'h08, 5'h1C, 4'h8, 0, 0};

    for (int i = 0; i < 8; i++) begin
      if (vt[i].rst) begin reset_dut(); exp_tn = 1; exp_ev = 1; end
      trig_type = vt[i].ty; chan_en = vt[i].ce; acq_activated = vt[i].act;
      seen = vt[i].sn; acq_ready = vt[i].rdy; xadc = vt[i].xa;
      ttc_trigger = 1; ts_exp = m_ts;
      step();
      ttc_trigger = 0;
      chk($sformatf("v%0d_state_wait", i), state, 1);
      chk($sformatf("v%0d_trig_num", i), trig_num, exp_tn + 24'd1);
      chk($sformatf("v%0d_acq_num", i), acq_trig_num, exp_tn);
      chk($sformatf("v%0d_acq_type", i), acq_trig_type, vt[i].ty);
      chk($sformatf("v%0d_tts", i), trig_timestamp, ts_exp);
      chk($sformatf("v%0d_no_early_pulse", i), acq_trigger, 0);
      step();
      w_exp = word(ts_exp, exp_tn, exp_ev, vt[i].ty, vt[i].e_ee, vt[i].xa, vt[i].e_ep, vt[i].ce);
      chk($sformatf("v%0d_pulse_T2", i), acq_trigger, !vt[i].e_ee);
      chk($sformatf("v%0d_valid_T2", i), fif.fifo_valid, 1);
      chk($sformatf("v%0d_word", i), fif.fifo_data, w_exp);
      chk($sformatf("v%0d_state_store", i), state, 2);
      if (!vt[i].e_ee) exp_ev++;
      exp_tn++;
      step();
      chk($sformatf("v%0d_pulse_1cyc", i), acq_trigger, 0);
      chk($sformatf("v%0d_word_hold", i), fif.fifo_data, w_exp);
      fif.fifo_ready = 1;
      step();
      fif.fifo_ready = 0;
      chk($sformatf("v%0d_valid_off", i), fif.fifo_valid, 0);
      chk($sformatf("v%0d_state_idle", i), state, 0);
    end

    // Ready timeout: two enabled channels never ready
    reset_dut();
    chan_en = 5'h03; acq_ready = 5'h1C; trig_type = ACC;
    ttc_trigger = 1; step(); ttc_trigger = 0;
    repeat (1023) step();
    chk("to_still_wait", state, 1);
    chk("to_flag_early", err_to, 0);
    step();
    chk("to_state_error", state, 3);
    chk("to_flag", err_to, 1);
    ttc_trigger = 1; step(); ttc_trigger = 0;
    chk("err_drop_cnt", dropped, 1);
    chk("err_drop_rate", err_rate, 1);
    chk("err_hold_state", state, 3);
    chk("err_no_valid", fif.fifo_valid, 0);
    chk("err_no_pulse", acq_trigger, 0);
    error_clear = 1; step(); error_clear = 0;
    chk("clr_state", state, 0);
    chk("clr_err_to", err_to, 0);
    chk("clr_err_rate", err_rate, 0);
    chk("clr_dropped", dropped, 0);

    // FIFO back-pressure with three triggers dropped during STORE
    reset_dut();
    trig_type = ACC; xadc = 4'h6;
    ttc_trigger = 1; ts_exp = m_ts; step(); ttc_trigger = 0; step();
    w_exp = word(ts_exp, 1, 1, ACC, 0, 4'h6, 0, 5'h1F);
    for (int k = 0; k < 10; k++) begin
      ttc_trigger = (k < 3);
      step();
      chk($sformatf("stall_word_%0d", k), {fif.fifo_valid, fif.fifo_data}, {1'b1, w_exp});
    end
    ttc_trigger = 0;
    chk("stall_dropped", dropped, 3);
    chk("stall_rate", err_rate, 1);
    chk("stall_trig_num", trig_num, 5);
    fif.fifo_ready = 1; step(); fif.fifo_ready = 0;
    chk("stall_release", {state, fif.fifo_valid}, {3'd0, 1'b0});

    // reset_trig_num coinciding with a trigger
    reset_dut();
    trig_type = ACC;
    ttc_trigger = 1; step(); ttc_trigger = 0; step();
    fif.fifo_ready = 1; step(); fif.fifo_ready = 0;
    chk("pre_rtn_trig_num", trig_num, 2);
    ttc_trigger = 1; rtn = 1; step(); ttc_trigger = 0; rtn = 0;
    chk("rtn_trig_num", trig_num, 1);
    chk("rtn_acq_num", acq_trig_num, 1);
    chk("rtn_state", state, 1);
    step();
    chk("rtn_word_num", fif.fifo_data[67:44], 1);
    chk("rtn_word_ev", fif.fifo_data[91:68], 1);

    // Reset while a word is pending in STORE
    reset = 1; step(); reset = 0;
    chk("rst_store_valid", fif.fifo_valid, 0);
    chk("rst_store_data", fif.fifo_data, 0);
    step();
    chk("rst_store_after", {state, fif.fifo_valid}, {3'd0, 1'b0});

    // Randomized run against the transaction-level model
    reset_dut();
    mtn = 1; mat = 1; mev = 1; mtts = 0; mdrop = 0; mrate = 0; busy = 0; shown = 0;
    m_type = 0; exp_w = '0; ev_ty = 0; ev_ce = 0; ev_xa = 0; ev_ee = 0; ev_ep = 0;
    for (int c = 0; c < 3000; c++) begin
      ttc_trigger   = ($urandom_range(3) == 0);
      trig_type     = ($urandom_range(9) < 7) ? ACC : 5'($urandom_range(31));
      chan_en       = 5'($urandom);
      acq_activated = 5'($urandom);
      seen          = 5'($urandom);
      acq_ready     = ($urandom_range(1) == 0) ? 5'h1F : 5'($urandom);
      xadc          = 4'($urandom);
      fif.fifo_ready = $urandom_range(1);
      rtn = ($urandom_range(63) == 0);
      rtt = ($urandom_range(63) == 0);

      cur_ts = m_ts;
      rdy = &(acq_ready | ~chan_en);
      pb = busy; ps = shown; exp_pulse = 0;
      if (pb && !ps && rdy) begin
        shown = 1;
        exp_pulse = !ev_ee;
        exp_w = word(mtts, mat, mev, ev_ty, ev_ee, ev_xa, ev_ep, ev_ce);
        if (!ev_ee) mev++;
      end
      if (pb && ps && fif.fifo_ready) begin busy = 0; shown = 0; end
      if (ttc_trigger) begin
        if (!pb) begin
          busy = 1;
          ev_ty = trig_type; ev_ce = chan_en; ev_xa = xadc;
          ev_ee = (trig_type != ACC) || (chan_en == 0) || ((acq_activated & chan_en) == 0);
          ev_ep = !ev_ee && ((seen & chan_en) == 0);
          mat = mtn; mtts = cur_ts; m_type = trig_type;
        end else begin
          mrate = 1;
          if (mdrop != 16'hFFFF) mdrop++;
        end
        mtn++;
      end
      if (rtn) begin mtn = 1; mat = 1; mev = 1; end
      if (rtt) mtts = 0;

      step();
      chk("rnd_pulse", acq_trigger, exp_pulse);
      chk("rnd_valid", fif.fifo_valid, shown);
      if (shown) chk("rnd_word", fif.fifo_data, exp_w);
      chk("rnd_state", state, shown ? 3'd2 : (busy ? 3'd1 : 3'd0));
      chk("rnd_trig_num", trig_num, mtn);
      chk("rnd_acq_num", acq_trig_num, mat);
      chk("rnd_acq_type", acq_trig_type, m_type);
      chk("rnd_tts", trig_timestamp, mtts);
      chk("rnd_dropped", dropped, mdrop);
      chk("rnd_rate", err_rate, mrate);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
